hex_step_counter: RTL and testbench

- Upstream neighbour of the switch-driven seven-segment display stage.
- Produces the 4-bit hex nibble (a,b,c,d; a = MSB) that the seven-segment decoder slots consume.
- The nibble is stepped up or down by a debounced push-button, with hold-to-auto-repeat.
- The nibble can also be parallel-loaded from the four slide switches.

---
 rtl/hex_step_counter_pkg.sv | 24 ++
 rtl/hex_step_counter_if.sv | 39 +++
 rtl/key_debouncer.sv | 57 +++++
 rtl/hex_step_counter.sv | 145 ++++++++++++++
 tb/tb_hex_step_counter.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_step_counter_pkg.sv
// Shared types and constants for the hex step counter.
package hex_step_counter_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Values at which an up-step or a down-step wraps around.
    localparam nibble_t NIBBLE_MAX = 4'hF;
    localparam nibble_t NIBBLE_MIN = 4'h0;

    // Key-repeat state machine.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    // Larger of two integers, for sizing the shared repeat timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hex_step_counter_if.sv
// Raw board inputs and the registered nibble outputs of the hex step counter.
// All signals are plain levels (no handshake); inputs are asynchronous to
// the clock and are synchronized inside the counter. dbg_state mirrors the
// key-repeat FSM for observation.
interface hex_step_counter_if;
    import hex_step_counter_pkg::*;

    logic   input_key_step_n;
    logic   input_dir_sw;
    logic   input_load_sw;
    logic   input_a_sw_3;
    logic   input_b_sw_2;
    logic   input_c_sw_1;
    logic   input_d_sw_0;
    logic   output_a_bit_3;
    logic   output_b_bit_2;
    logic   output_c_bit_1;
    logic   output_d_bit_0;
    logic   output_step_pulse;
    logic   output_wrap_pulse;
    state_t dbg_state;

    // Board / testbench side: drives the raw inputs.
    modport master (
        output input_key_step_n, input_dir_sw, input_load_sw,
        output input_a_sw_3, input_b_sw_2, input_c_sw_1, input_d_sw_0,
        input  output_a_bit_3, output_b_bit_2, output_c_bit_1, output_d_bit_0,
        input  output_step_pulse, output_wrap_pulse, dbg_state
    );

    // Counter side.
    modport slave (
        input  input_key_step_n, input_dir_sw, input_load_sw,
        input  input_a_sw_3, input_b_sw_2, input_c_sw_1, input_d_sw_0,
        output output_a_bit_3, output_b_bit_2, output_c_bit_1, output_d_bit_0,
        output output_step_pulse, output_wrap_pulse, dbg_state
    );

endinterface

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus stable-sample debouncer for an active-low key.
// key_level is the clean pressed level (1 = pressed); press_evt pulses for
// one cycle in the same cycle key_level rises.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_n,
    output logic key_level,
    output logic press_evt
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             sample;
    logic [CNT_W-1:0] stable_cnt;

    // Inverted after sync so that pressed reads as 1.
    assign sample = ~sync_2;

    // Synchronize the raw key; reset to the released (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key_raw_n;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_level  <= 1'b0;
            stable_cnt <= '0;
            press_evt  <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (sample != key_level) begin
                if (stable_cnt == CNT_LAST) begin
                    key_level  <= sample;
                    stable_cnt <= '0;
                    press_evt  <= sample;
                end else begin
                    stable_cnt <= stable_cnt + CNT_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/hex_step_counter.sv
// Hex nibble counter stepped by a debounced push-button with hold-to-repeat,
// and parallel-loadable from four slide switches. Feeds the 7-segment decoder.
module hex_step_counter
    import hex_step_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 10000000
) (
    input  logic              input_clock,
    input  logic              input_reset,
    hex_step_counter_if.slave bus
);
    localparam int TIMER_MAX = max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD_CYCLES - 1);

    logic               key_level;
    logic               press_evt;
    logic [5:0]         sw_meta;
    logic [5:0]         sw_sync;
    logic               dir_sync;
    logic               load_sync;
    nibble_t            data_sync;
    state_t             state;
    logic [TIMER_W-1:0] timer;
    nibble_t            nibble;
    logic               step_pulse;
    logic               wrap_pulse;
    logic               step_req;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
        .clk       (input_clock),
        .rst       (input_reset),
        .key_raw_n (bus.input_key_step_n),
        .key_level (key_level),
        .press_evt (press_evt)
    );

    // Plain two-flop synchronizers for the slide switches.
    always_ff @(posedge input_clock or posedge input_reset) begin
        if (input_reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= {bus.input_dir_sw, bus.input_load_sw, bus.input_a_sw_3,
                        bus.input_b_sw_2, bus.input_c_sw_1, bus.input_d_sw_0};
            sw_sync <= sw_meta;
        end
    end

    assign dir_sync  = sw_sync[5];
    assign load_sync = sw_sync[4];
    assign data_sync = sw_sync[3:0];

    // A step is due on first press or on timer expiry while the clean key is held;
    // a release seen in the expiry cycle cancels the step.
    always_comb begin
        step_req = 1'b0;
        case (state)
            S_IDLE:   step_req = press_evt;
            S_HOLD:   step_req = key_level && (timer == DELAY_LAST);
            S_REPEAT: step_req = key_level && (timer == PERIOD_LAST);
            default:  step_req = 1'b0;
        endcase
    end

    // Key-repeat FSM: first step, long initial delay, then periodic repeats.
    always_ff @(posedge input_clock or posedge input_reset) begin
        if (input_reset) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (press_evt) begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!key_level) begin
                        state <= S_IDLE;
                        timer <= '0;
                    end else if (timer == DELAY_LAST) begin
                        state <= S_REPEAT;
                        timer <= '0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                S_REPEAT: begin
                    if (!key_level) begin
                        state <= S_IDLE;
                        timer <= '0;
                    end else if (timer == PERIOD_LAST) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // Nibble register: load overrides stepping and silences the pulses.
    always_ff @(posedge input_clock or posedge input_reset) begin
        if (input_reset) begin
            nibble     <= NIBBLE_MIN;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            if (load_sync) begin
                nibble <= data_sync;
            end else if (step_req) begin
                step_pulse <= 1'b1;
                if (dir_sync) begin
                    nibble     <= nibble + nibble_t'(1);
                    wrap_pulse <= (nibble == NIBBLE_MAX);
                end else begin
                    nibble     <= nibble - nibble_t'(1);
                    wrap_pulse <= (nibble == NIBBLE_MIN);
                end
            end
        end
    end

    assign bus.output_a_bit_3    = nibble[3];
    assign bus.output_b_bit_2    = nibble[2];
    assign bus.output_c_bit_1    = nibble[1];
    assign bus.output_d_bit_0    = nibble[0];
    assign bus.output_step_pulse = step_pulse;
    assign bus.output_wrap_pulse = wrap_pulse;
    assign bus.dbg_state         = state;

endmodule

// File: tb/tb_hex_step_counter.sv
// Testbench for hex_step_counter: directed vectors, hand-written multi-cycle
// sequences, and randomized stimulus checked against a behavioural model.
module tb_hex_step_counter;
    import hex_step_counter_pkg::*;

    localparam int D      = 4;
    localparam int DELAY  = 20;
    localparam int PERIOD = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hex_step_counter_if bus();

    hex_step_counter #(
        .DEBOUNCE_CYCLES      (D),
        .REPEAT_DELAY_CYCLES  (DELAY),
        .REPEAT_PERIOD_CYCLES (PERIOD)
    ) dut (
        .input_clock (clk),
        .input_reset (rst),
        .bus         (bus)
    );

    int n_checks   = 0;
    int n_errors   = 0;
    int step_count = 0;
    int cyc        = 0;
    int step_times[$];

    // ---------------- reference model ----------------
    // Raw inputs as seen at each clock edge; any value takes effect two edges
    // later. The key level flips once the last D synchronized samples all
    // disagree with it; steps follow the hold timing measured in edges.
    typedef struct packed {
        logic       key_p;
        logic       dir;
        logic       load;
        logic [3:0] data;
    } raw_t;

    raw_t       hist[$];
    bit         m_clean, m_press, m_held, m_step, m_wrap;
    int         m_since, m_nsteps;
    logic [3:0] m_nib;

    task automatic model_reset();
        raw_t idle_v;
        idle_v = '0;
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(idle_v);
        m_clean = 0; m_press = 0; m_held = 0; m_step = 0; m_wrap = 0;
        m_since = 0; m_nsteps = 0; m_nib = 4'h0;
    endtask

    task automatic model_step();
        raw_t now, syn;
        bit   c_prev, pe_prev, step, all_diff;
        now.key_p = ~bus.input_key_step_n;
        now.dir   = bus.input_dir_sw;
        now.load  = bus.input_load_sw;
        now.data  = {bus.input_a_sw_3, bus.input_b_sw_2, bus.input_c_sw_1, bus.input_d_sw_0};
        hist.push_back(now);
        if (hist.size() > D + 2) void'(hist.pop_front());
        syn     = hist[hist.size() - 3];
        c_prev  = m_clean;
        pe_prev = m_press;
        step    = 0;
        if (!m_held) begin
            if (pe_prev) begin
                step = 1; m_held = 1; m_since = 0; m_nsteps = 1;
            end
        end else if (!c_prev) begin
            m_held = 0;
        end else begin
            m_since++;
            if (m_since == ((m_nsteps == 1) ? DELAY : PERIOD)) begin
                step = 1; m_since = 0; m_nsteps++;
            end
        end
        m_step = 0;
        m_wrap = 0;
        if (syn.load) begin
            m_nib = syn.data;
        end else if (step) begin
            m_step = 1;
            if (syn.dir) begin
                m_wrap = (m_nib == 4'd15);
                m_nib  = 4'((int'(m_nib) + 1) % 16);
            end else begin
                m_wrap = (m_nib == 4'd0);
                m_nib  = 4'((int'(m_nib) + 15) % 16);
            end
        end
        all_diff = 1;
        for (int i = 0; i < D; i++) begin
            if (hist[hist.size() - 3 - i].key_p == m_clean) all_diff = 0;
        end
        m_press = 0;
        if (all_diff) begin
            m_clean = ~m_clean;
            m_press = m_clean;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    function automatic logic [3:0] cur_nib();
        return {bus.output_a_bit_3, bus.output_b_bit_2, bus.output_c_bit_1, bus.output_d_bit_0};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_key(input bit pressed);
        bus.input_key_step_n = ~pressed;
    endtask

    task automatic set_data(input logic [3:0] v);
        bus.input_a_sw_3 = v[3];
        bus.input_b_sw_2 = v[2];
        bus.input_c_sw_1 = v[1];
        bus.input_d_sw_0 = v[0];
    endtask

    // One clock: model advances at the edge, DUT is compared at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        cyc++;
        if (!rst) begin
            chk("model_nibble", 32'(cur_nib()), 32'(m_nib));
            chk("model_step", 32'(bus.output_step_pulse), 32'(m_step));
            chk("model_wrap", 32'(bus.output_wrap_pulse), 32'(m_wrap));
            chk("model_held", 32'(bus.dbg_state != S_IDLE), 32'(m_held));
            if (bus.output_step_pulse === 1'b1) begin
                step_count++;
                step_times.push_back(cyc);
            end
        end
    endtask

    task automatic wait_step(input int max_cycles, input string name, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            cycle();
            if (bus.output_step_pulse === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no step within %0d cycles", name, max_cycles);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_nibble", 32'(cur_nib()), 32'(4'h0));
        chk("reset_step", 32'(bus.output_step_pulse), 32'(1'b0));
        chk("reset_wrap", 32'(bus.output_wrap_pulse), 32'(1'b0));
        chk("reset_state", 32'(bus.dbg_state), 32'(S_IDLE));
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic load_value(input logic [3:0] v);
        bus.input_load_sw = 1'b1;
        set_data(v);
        repeat (4) cycle();
        chk("load_value", 32'(cur_nib()), 32'(v));
        bus.input_load_sw = 1'b0;
        repeat (3) cycle();
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [3:0] data;
        logic       dir;
        logic [3:0] exp_nib;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[6];
    int   rep_off[6];

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        int lat, sc0, key_run, load_run;
        bit kp;

        vecs[0] = '{data: 4'h0, dir: 1'b1, exp_nib: 4'h1, exp_wrap: 1'b0};
        vecs[1] = '{data: 4'hF, dir: 1'b1, exp_nib: 4'h0, exp_wrap: 1'b1};
        vecs[2] = '{data: 4'h0, dir: 1'b0, exp_nib: 4'hF, exp_wrap: 1'b1};
        vecs[3] = '{data: 4'h7, dir: 1'b0, exp_nib: 4'h6, exp_wrap: 1'b0};
        vecs[4] = '{data: 4'hA, dir: 1'b1, exp_nib: 4'hB, exp_wrap: 1'b0};
        vecs[5] = '{data: 4'h8, dir: 1'b0, exp_nib: 4'h7, exp_wrap: 1'b0};
        rep_off = '{0, 20, 28, 36, 44, 52};

        set_key(1'b0);
        bus.input_dir_sw  = 1'b1;
        bus.input_load_sw = 1'b0;
        set_data(4'h0);
        repeat (3) @(negedge clk);
        model_reset();
        rst = 1'b0;
        chk("init_nibble", 32'(cur_nib()), 32'(4'h0));
        chk("init_step", 32'(bus.output_step_pulse), 32'(1'b0));
        chk("init_wrap", 32'(bus.output_wrap_pulse), 32'(1'b0));
        chk("init_state", 32'(bus.dbg_state), 32'(S_IDLE));
        repeat (3) cycle();

        // Clean press from 0, up: step 7 cycles after the edge.
        sc0 = step_count;
        set_key(1'b1);
        wait_step(12, "clean_press", lat);
        chk("clean_latency", 32'(lat), 32'(7));
        chk("clean_nibble", 32'(cur_nib()), 32'(4'h1));
        chk("clean_wrap", 32'(bus.output_wrap_pulse), 32'(1'b0));
        repeat (3) cycle();
        set_key(1'b0);
        repeat (15) cycle();
        chk("clean_steps", 32'(step_count - sc0), 32'(1));

        // Bouncy press then steady hold: exactly one step.
        sc0 = step_count;
        for (int s = 0; s < 6; s++) begin
            set_key(s % 2 == 0);
            repeat (2) cycle();
        end
        set_key(1'b1);
        repeat (14) cycle();
        set_key(1'b0);
        repeat (15) cycle();
        chk("bounce_steps", 32'(step_count - sc0), 32'(1));
        chk("bounce_nibble", 32'(cur_nib()), 32'(4'h2));

        // Glitch shorter than the debounce window: no step.
        sc0 = step_count;
        set_key(1'b1);
        repeat (3) cycle();
        set_key(1'b0);
        repeat (15) cycle();
        chk("glitch_steps", 32'(step_count - sc0), 32'(0));

        // Table: load a start value, one press, check result and wrap.
        foreach (vecs[i]) begin
            bus.input_dir_sw = vecs[i].dir;
            load_value(vecs[i].data);
            set_key(1'b1);
            wait_step(15, "vec_step", lat);
            chk("vec_nibble", 32'(cur_nib()), 32'(vecs[i].exp_nib));
            chk("vec_wrap", 32'(bus.output_wrap_pulse), 32'(vecs[i].exp_wrap));
            set_key(1'b0);
            repeat (12) cycle();
        end

        // Hold-to-repeat from 0, up.
        bus.input_dir_sw = 1'b1;
        load_value(4'h0);
        step_times.delete();
        set_key(1'b1);
        wait_step(15, "repeat_first", lat);
        repeat (50) cycle();
        set_key(1'b0);
        repeat (20) cycle();
        chk("repeat_count", 32'(step_times.size()), 32'(6));
        if (step_times.size() == 6) begin
            for (int i = 0; i < 6; i++)
                chk("repeat_offset", 32'(step_times[i] - step_times[0]), 32'(rep_off[i]));
        end
        chk("repeat_nibble", 32'(cur_nib()), 32'(4'h6));

        // Load priority while repeating, then resume from the loaded value.
        load_value(4'h0);
        set_key(1'b1);
        wait_step(15, "lp_first", lat);
        repeat (30) cycle();
        bus.input_load_sw = 1'b1;
        set_data(4'hA);
        sc0 = step_count;
        repeat (30) cycle();
        chk("lp_no_pulses", 32'(step_count - sc0), 32'(0));
        chk("lp_nibble", 32'(cur_nib()), 32'(4'hA));
        bus.input_load_sw = 1'b0;
        wait_step(20, "lp_resume", lat);
        chk("lp_resume_nibble", 32'(cur_nib()), 32'(4'hB));
        set_key(1'b0);
        repeat (15) cycle();

        // Reset mid-hold with nibble 5; held key gives exactly one new step.
        load_value(4'h5);
        set_key(1'b1);
        repeat (3) cycle();
        chk("pre_reset_nibble", 32'(cur_nib()), 32'(4'h5));
        do_reset();
        sc0 = step_count;
        wait_step(12, "post_reset_step", lat);
        chk("post_reset_latency", 32'(lat), 32'(7));
        chk("post_reset_nibble", 32'(cur_nib()), 32'(4'h1));
        repeat (12) cycle();
        set_key(1'b0);
        repeat (15) cycle();
        chk("post_reset_steps", 32'(step_count - sc0), 32'(1));

        // Randomized stimulus against the model.
        kp = 0;
        key_run = 0;
        load_run = 0;
        for (int i = 0; i < 2500; i++) begin
            if (key_run == 0) begin
                kp = ~kp;
                key_run = int'($urandom_range(1, 70));
            end
            key_run--;
            set_key(kp);
            if ($urandom_range(0, 40) == 0) bus.input_dir_sw = ~bus.input_dir_sw;
            if (load_run == 0 && $urandom_range(0, 80) == 0) load_run = int'($urandom_range(1, 10));
            bus.input_load_sw = (load_run > 0);
            if (load_run > 0) load_run--;
            set_data(4'($urandom_range(0, 15)));
            if (i == 1200) do_reset();
            cycle();
        end
        set_key(1'b0);
        bus.input_load_sw = 1'b0;
        repeat (15) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
